slice_sweep_gen: RTL and testbench

- Stimulus sequencer that sits directly upstream of the interface-array-slice instance under test.
- Enumerates every legal (inner_left, inner_right, inner_offset) slice of an outer array range [LEFT:RIGHT].
- For each slice it streams an xs counter sequence 1, 2, …, 2^XS_W−1, 0 over a valid/ready handshake.
- The downstream instance/checker consumes one beat per transfer. Replaces elaborate-time genvar sweeps with a runtime-sequenced stream.

---
 rtl/slice_sweep_gen.sv | 121 ++++++++++++
 tb/tb_slice_sweep_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_sweep_gen.sv
// slice_sweep_gen: walks every legal (left, right, offset) slice of the outer
// range [BASE : BASE+DIR*(SIZE-1)] and streams an xs sequence 1..2^XS_W-1, 0
// for each slice over a valid/ready handshake, one beat per cycle when ready.
module slice_sweep_gen #(
    parameter int BASE     = 0,
    parameter int SIZE     = 4,
    parameter int DIR      = 1,
    parameter int OFF_SPAN = 2,
    parameter int XS_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic signed [7:0]      out_left,
    output logic signed [7:0]      out_right,
    output logic signed [7:0]      out_offset,
    output logic [XS_W-1:0]        out_xs,
    output logic                   out_last,
    output logic [15:0]            out_index,
    output logic                   out_done
);

    localparam int RIGHT_I = BASE + DIR * (SIZE - 1);
    localparam int LO_I    = (BASE < RIGHT_I) ? BASE : RIGHT_I;
    localparam int HI_I    = (BASE < RIGHT_I) ? RIGHT_I : BASE;

    localparam logic signed [7:0] LO   = 8'(LO_I);
    localparam logic signed [7:0] HI   = 8'(HI_I);
    localparam logic signed [7:0] OSP  = 8'(OFF_SPAN);
    localparam logic signed [7:0] NOSP = 8'(-OFF_SPAN);
    localparam logic [XS_W-1:0]   XS_ONE = XS_W'(1);
    localparam logic [XS_W-1:0]   XS_MAX = {XS_W{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic              xfer;
    logic              load;
    logic              off_wrap;
    logic              right_wrap;
    logic              final_beat;
    logic signed [7:0] right_end;
    logic signed [7:0] right_reload;

    assign out_valid = (state == RUN);
    assign out_done  = (state == DONE);

    // Advance conditions for the nested counters. The right index runs
    // left..hi when ascending and lo..left when descending, so only legal
    // pairs are ever produced.
    always_comb begin
        xfer         = (state == RUN) && out_ready;
        load         = (state != RUN) && start;
        off_wrap     = (out_offset == OSP);
        right_end    = (DIR > 0) ? HI : out_left;
        right_reload = (DIR > 0) ? (out_left + 8'sd1) : LO;
        right_wrap   = (out_right == right_end);
        final_beat   = out_last && off_wrap && right_wrap && (out_left == HI);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: start is only honoured outside RUN; the final transfer ends the sweep.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (xfer && final_beat) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Tuple / xs / index counters. The final transfer leaves the fields on the
    // last beat so DONE shows where the sweep ended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_left   <= '0;
            out_right  <= '0;
            out_offset <= '0;
            out_xs     <= '0;
            out_last   <= 1'b0;
            out_index  <= '0;
        end else if (load) begin
            out_left   <= LO;
            out_right  <= LO;
            out_offset <= NOSP;
            out_xs     <= XS_ONE;
            out_last   <= (XS_ONE == '0);
            out_index  <= '0;
        end else if (xfer && !final_beat) begin
            out_index <= out_index + 16'd1;
            if (out_last) begin
                out_xs   <= XS_ONE;
                out_last <= 1'b0;
                if (!off_wrap) begin
                    out_offset <= out_offset + 8'sd1;
                end else begin
                    out_offset <= NOSP;
                    if (!right_wrap) begin
                        out_right <= out_right + 8'sd1;
                    end else begin
                        out_left  <= out_left + 8'sd1;
                        out_right <= right_reload;
                    end
                end
            end else begin
                out_xs   <= out_xs + XS_ONE;
                out_last <= (out_xs == XS_MAX);
            end
        end
    end

endmodule

// File: tb/tb_slice_sweep_gen.sv
// Bench for slice_sweep_gen: three instances (ascending, descending,
// single-element) share clock and reset; a queue holds expected beats built
// by a nested-loop enumeration and is drained as the selected DUT transfers.
module tb_slice_sweep_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1;
    logic [2:0] st  = '0;
    logic [2:0] rdy = '0;

    logic              a_valid, b_valid, c_valid;
    logic signed [7:0] a_left, a_right, a_offset;
    logic signed [7:0] b_left, b_right, b_offset;
    logic signed [7:0] c_left, c_right, c_offset;
    logic [1:0]        a_xs, b_xs;
    logic [0:0]        c_xs;
    logic              a_last, b_last, c_last;
    logic [15:0]       a_index, b_index, c_index;
    logic              a_done, b_done, c_done;

    slice_sweep_gen #(.BASE(0), .SIZE(2), .DIR(1), .OFF_SPAN(0), .XS_W(2)) u_a (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .out_ready(rdy[0]),
        .out_valid(a_valid), .out_left(a_left), .out_right(a_right),
        .out_offset(a_offset), .out_xs(a_xs), .out_last(a_last),
        .out_index(a_index), .out_done(a_done));

    slice_sweep_gen #(.BASE(0), .SIZE(2), .DIR(-1), .OFF_SPAN(0), .XS_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .out_ready(rdy[1]),
        .out_valid(b_valid), .out_left(b_left), .out_right(b_right),
        .out_offset(b_offset), .out_xs(b_xs), .out_last(b_last),
        .out_index(b_index), .out_done(b_done));

    slice_sweep_gen #(.BASE(-2), .SIZE(1), .DIR(1), .OFF_SPAN(2), .XS_W(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .out_ready(rdy[2]),
        .out_valid(c_valid), .out_left(c_left), .out_right(c_right),
        .out_offset(c_offset), .out_xs(c_xs), .out_last(c_last),
        .out_index(c_index), .out_done(c_done));

    typedef struct packed {
        logic              v;
        logic signed [7:0] l;
        logic signed [7:0] r;
        logic signed [7:0] o;
        logic [7:0]        xs;
        logic              last;
        logic [15:0]       idx;
        logic              done;
    } beat_t;

    beat_t q[$];
    beat_t obs;
    int    sel = 0;
    int    checks = 0;
    int    failures = 0;

    // Observed beat of the currently selected instance.
    always_comb begin
        obs = '0;
        if (sel == 0) begin
            obs.v = a_valid; obs.l = a_left; obs.r = a_right; obs.o = a_offset;
            obs.xs = 8'(a_xs); obs.last = a_last; obs.idx = a_index; obs.done = a_done;
        end else if (sel == 1) begin
            obs.v = b_valid; obs.l = b_left; obs.r = b_right; obs.o = b_offset;
            obs.xs = 8'(b_xs); obs.last = b_last; obs.idx = b_index; obs.done = b_done;
        end else begin
            obs.v = c_valid; obs.l = c_left; obs.r = c_right; obs.o = c_offset;
            obs.xs = 8'(c_xs); obs.last = c_last; obs.idx = c_index; obs.done = c_done;
        end
    end

    function automatic void push_sweep(input int base, input int size, input int dir,
                                       input int osp, input int xsw);
        int    rt;
        int    lo;
        int    hi;
        int    rs;
        int    re;
        int    idx;
        int    n;
        beat_t b;
        rt  = base + dir * (size - 1);
        lo  = (base < rt) ? base : rt;
        hi  = (base < rt) ? rt : base;
        idx = 0;
        n   = 1 << xsw;
        for (int l = lo; l <= hi; l++) begin
            rs = (dir > 0) ? l : lo;
            re = (dir > 0) ? hi : l;
            for (int r = rs; r <= re; r++)
                for (int o = -osp; o <= osp; o++)
                    for (int k = 1; k <= n; k++) begin
                        b      = '0;
                        b.v    = 1'b1;
                        b.l    = 8'(l);
                        b.r    = 8'(r);
                        b.o    = 8'(o);
                        b.xs   = 8'(k % n);
                        b.last = (k == n);
                        b.idx  = 16'(idx);
                        q.push_back(b);
                        idx++;
                    end
        end
    endfunction

    task automatic show_fail(input string name, input beat_t got, input beat_t exp);
        $display("FAIL %s got v=%0b l=%0d r=%0d o=%0d xs=%0d last=%0b idx=%0d done=%0b expected v=%0b l=%0d r=%0d o=%0d xs=%0d last=%0b idx=%0d done=%0b",
                 name, got.v, got.l, got.r, got.o, got.xs, got.last, got.idx, got.done,
                 exp.v, exp.l, exp.r, exp.o, exp.xs, exp.last, exp.idx, exp.done);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        st[sel]  = 1'b1;
        rdy[sel] = 1'b1;
        @(negedge clk);
        st[sel] = 1'b0;
    endtask

    // Consume n beats; optionally stall at one index and pulse start at another.
    task automatic drain(input int n, input int stall_idx, input int stall_len, input int start_idx);
        int    got;
        int    stalled;
        beat_t exp;
        got     = 0;
        stalled = 0;
        for (int cyc = 0; cyc < 200 && got < n; cyc++) begin
            st[sel] = (obs.v && obs.idx == 16'(start_idx));
            if (obs.v && obs.idx == 16'(stall_idx) && stalled < stall_len) begin
                rdy[sel] = 1'b0;
                stalled++;
                exp = (q.size() > 0) ? q[0] : '0;
                checks++;
                if (obs !== exp) begin failures++; show_fail("stall_hold", obs, exp); end
            end else begin
                rdy[sel] = 1'b1;
                if (obs.v) begin
                    exp = (q.size() > 0) ? q.pop_front() : '0;
                    checks++;
                    if (obs !== exp) begin failures++; show_fail("beat", obs, exp); end
                    got++;
                end
            end
            @(negedge clk);
        end
        st[sel] = 1'b0;
        if (got < n) begin
            checks++; failures++;
            $display("FAIL timeout got %0d beats expected %0d", got, n);
        end
        checks++;
        if (obs.v !== 1'b0 || obs.done !== 1'b1) begin
            failures++;
            $display("FAIL done_state got valid=%0b done=%0b expected valid=0 done=1", obs.v, obs.done);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #10;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if (obs !== '0) begin failures++; show_fail("reset_state", obs, '0); end
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ascending();
        sel = 0;
        push_sweep(0, 2, 1, 0, 2);
        pulse_start();
        drain(12, -1, 0, -1);
    endtask

    task automatic test_backpressure();
        sel = 0;
        push_sweep(0, 2, 1, 0, 2);
        pulse_start();
        drain(12, 5, 3, -1);
    endtask

    task automatic test_start_ignored_and_replay();
        sel = 0;
        push_sweep(0, 2, 1, 0, 2);
        pulse_start();
        drain(12, -1, 0, 3);
        push_sweep(0, 2, 1, 0, 2);
        pulse_start();
        drain(12, -1, 0, -1);
    endtask

    task automatic test_async_reset();
        int    found;
        beat_t exp;
        sel   = 0;
        found = 0;
        push_sweep(0, 2, 1, 0, 2);
        pulse_start();
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (obs.v && obs.idx == 16'd7) begin found = 1; break; end
            rdy[sel] = 1'b1;
            if (obs.v) begin
                exp = (q.size() > 0) ? q.pop_front() : '0;
                checks++;
                if (obs !== exp) begin failures++; show_fail("pre_reset_beat", obs, exp); end
            end
            @(negedge clk);
        end
        checks++;
        if (found == 0) begin failures++; $display("FAIL reach_index7 got no beat 7 expected one"); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin failures++; show_fail("async_reset", obs, '0); end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        push_sweep(0, 2, 1, 0, 2);
        pulse_start();
        drain(12, -1, 0, -1);
    endtask

    task automatic test_descending();
        sel = 1;
        push_sweep(0, 2, -1, 0, 2);
        pulse_start();
        drain(12, -1, 0, -1);
    endtask

    task automatic test_single();
        sel = 2;
        push_sweep(-2, 1, 1, 2, 1);
        pulse_start();
        drain(10, -1, 0, -1);
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_backpressure();
        test_start_ignored_and_replay();
        test_async_reset();
        test_descending();
        test_single();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expected got %0d queued expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
